// File: rtl/cordic_prestage_pipe_pkg.sv
// Shared types and helpers for the CORDIC pre-stage: mode encoding, quadrant type,
// turn fractions and the negation helper that optionally saturates the most-negative value.
package cordic_pkg;

   typedef enum logic {
      CORDIC_ROT = 1'b0,
      CORDIC_VEC = 1'b1
   } cordic_mode_e;

   typedef logic [1:0] quadrant_t;

   function automatic int quarter_turn(input int aw);
      return 1 << (aw - 2);
   endfunction

   function automatic int half_turn(input int aw);
      return 1 << (aw - 1);
   endfunction

   // v is sign-extended from dw bits; the caller keeps the low dw bits of the result.
   function automatic logic [63:0] sat_neg(input logic [63:0] v, input int dw, input logic sat_en);
      logic [63:0] min_v;
      logic [63:0] res;
      min_v = {64{1'b1}} << (dw - 1);
      res   = 64'd0 - v;
      if (sat_en && (v == min_v)) begin
         res = ~min_v;
      end
      return res;
   endfunction

endpackage

// File: rtl/cordic_prestage_pipe_skid.sv
// Generic 2-entry valid/ready buffer: an output register plus one skid register so that
// in_ready depends only on registered state and full throughput is kept.
module cordic_skid_buf
   import cordic_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         r_out_valid;
   logic [W-1:0] r_out_data;
   logic         r_skid_valid;
   logic [W-1:0] r_skid_data;
   logic         w_accept;
   logic         w_load;

   assign in_ready  = rst_n & ~r_skid_valid;
   assign w_accept  = in_valid & in_ready;
   assign w_load    = ~r_out_valid | out_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (w_load) begin
         // A full skid implies in_ready=0, so it never competes with a new beat here.
         if (r_skid_valid) begin
            r_out_data   <= r_skid_data;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
               r_out_data <= in_data;
            end
         end
      end else if (w_accept) begin
         r_skid_data  <= in_data;
         r_skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/cordic_prestage_pipe.sv
// CORDIC input stage: folds the operand into quadrant 0 and registers it through a skid buffer.
// Define CORDIC_PRESTAGE_SAT_EN to saturate negation of the most-negative value and flag it on out_sat.
module cordic_prestage_pipe
   import cordic_pkg::*;
#(
   parameter int DW    = 16,
   parameter int AW    = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [DW-1:0]    in_x,
   input  logic [DW-1:0]    in_y,
   input  logic [AW-1:0]    in_theta,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_mode,
   output logic [DW-1:0]    out_x,
   output logic [DW-1:0]    out_y,
   output logic [AW-1:0]    out_theta,
   output logic [1:0]       out_quadrant,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_sat
);

`ifdef CORDIC_PRESTAGE_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   localparam int            WORD_W = 1 + 2*DW + AW + 2 + TAG_W + 1;
   localparam logic [AW-1:0] QMASK  = AW'(quarter_turn(AW) - 1);
   localparam logic [DW-1:0] MIN_V  = {1'b1, {(DW-1){1'b0}}};

   cordic_mode_e      w_mode;
   quadrant_t         w_q;
   logic [63:0]       w_x_ext;
   logic [63:0]       w_y_ext;
   logic [DW-1:0]     w_neg_x;
   logic [DW-1:0]     w_neg_y;
   logic              w_min_x;
   logic              w_min_y;
   logic [DW-1:0]     w_x;
   logic [DW-1:0]     w_y;
   logic [AW-1:0]     w_theta;
   logic              w_sat;
   logic [WORD_W-1:0] w_in_word;
   logic [WORD_W-1:0] w_out_word;

   assign w_mode  = cordic_mode_e'(in_mode);
   assign w_x_ext = {{(64-DW){in_x[DW-1]}}, in_x};
   assign w_y_ext = {{(64-DW){in_y[DW-1]}}, in_y};
   assign w_neg_x = DW'(sat_neg(w_x_ext, DW, SAT_EN));
   assign w_neg_y = DW'(sat_neg(w_y_ext, DW, SAT_EN));
   assign w_min_x = SAT_EN & (in_x == MIN_V);
   assign w_min_y = SAT_EN & (in_y == MIN_V);

   always_comb begin
      w_x   = in_x;
      w_y   = in_y;
      w_sat = 1'b0;
      // Vectoring: q[1] is the y sign, q[0] flips between the left/right half-planes.
      if (w_mode == CORDIC_VEC) begin
         w_q     = {in_y[DW-1], in_x[DW-1] ^ in_y[DW-1]};
         w_theta = AW'(w_q) << (AW - 2);
      end else begin
         w_q     = in_theta[AW-1:AW-2];
         w_theta = in_theta & QMASK;
      end
      case (w_q)
         2'd1: begin
            w_x   = in_y;
            w_y   = w_neg_x;
            w_sat = w_min_x;
         end
         2'd2: begin
            w_x   = w_neg_x;
            w_y   = w_neg_y;
            w_sat = w_min_x | w_min_y;
         end
         2'd3: begin
            w_x   = w_neg_y;
            w_y   = in_x;
            w_sat = w_min_y;
         end
         default: begin
            w_x   = in_x;
            w_y   = in_y;
            w_sat = 1'b0;
         end
      endcase
   end

   assign w_in_word = {in_mode, w_x, w_y, w_theta, w_q, in_tag, w_sat};

   cordic_skid_buf #(
      .W(WORD_W)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (w_in_word),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (w_out_word)
   );

   assign {out_mode, out_x, out_y, out_theta, out_quadrant, out_tag, out_sat} = w_out_word;

endmodule

// File: tb/tb_cordic_prestage_pipe.sv
// Self-checking bench for cordic_prestage_pipe: vector table, back-pressure, mid-stream reset
// and a 100-beat random stream, all checked through an expected-result queue.
module tb_cordic_prestage_pipe;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int TW = 4;
`ifdef CORDIC_PRESTAGE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam logic [15:0] SX = SAT ? 16'h7FFF : 16'h8000;

   typedef struct {
      logic        mode;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] theta;
      logic [1:0]  q;
      logic [3:0]  tag;
      logic        sat;
   } beat_t;

   typedef struct {
      logic        mode;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] theta;
      logic [3:0]  tag;
      beat_t       exp;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_mode;
   logic [DW-1:0] in_x;
   logic [DW-1:0] in_y;
   logic [AW-1:0] in_theta;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic          out_mode;
   logic [DW-1:0] out_x;
   logic [DW-1:0] out_y;
   logic [AW-1:0] out_theta;
   logic [1:0]    out_quadrant;
   logic [TW-1:0] out_tag;
   logic          out_sat;

   int    checks;
   int    failures;
   int    n_out;
   beat_t sb[$];
   beat_t cur_exp;
   vec_t  tbl[9];

   cordic_prestage_pipe #(.DW(DW), .AW(AW), .TAG_W(TW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mode     (in_mode),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_theta    (in_theta),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_mode    (out_mode),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_theta   (out_theta),
      .out_quadrant(out_quadrant),
      .out_tag     (out_tag),
      .out_sat     (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [55:0] pack(input beat_t b);
      return {b.mode, b.x, b.y, b.theta, b.q, b.tag, b.sat};
   endfunction

   function automatic logic [16:0] bneg(input logic [15:0] v);
      int s;
      s = $signed(v);
      if (s == -32768) return SAT ? {1'b1, 16'h7FFF} : {1'b0, 16'h8000};
      return {1'b0, 16'(-s)};
   endfunction

   function automatic beat_t model(input logic mode, input logic [15:0] x, input logic [15:0] y,
                                   input logic [15:0] th, input logic [3:0] tag);
      beat_t       b;
      logic [16:0] nx;
      logic [16:0] ny;
      int          q;
      nx = bneg(x);
      ny = bneg(y);
      if (mode) begin
         if ($signed(x) >= 0 && $signed(y) >= 0)     q = 0;
         else if ($signed(x) < 0 && $signed(y) >= 0) q = 1;
         else if ($signed(x) < 0)                    q = 2;
         else                                        q = 3;
         b.theta = 16'(q * 16384);
      end else begin
         q       = int'(th) / 16384;
         b.theta = 16'(int'(th) % 16384);
      end
      b.mode = mode;
      b.tag  = tag;
      b.q    = 2'(q);
      case (q)
         0:       begin b.x = x;         b.y = y;         b.sat = 1'b0;            end
         1:       begin b.x = y;         b.y = nx[15:0];  b.sat = nx[16];          end
         2:       begin b.x = nx[15:0];  b.y = ny[15:0];  b.sat = nx[16] | ny[16]; end
         default: begin b.x = ny[15:0];  b.y = x;         b.sat = ny[16];          end
      endcase
      return b;
   endfunction

   function automatic vec_t mkv(input logic mode, input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] th, input logic [3:0] tag, input logic [1:0] q,
                                input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] eth,
                                input logic esat);
      vec_t v;
      v.mode = mode;  v.x = x;  v.y = y;  v.theta = th;  v.tag = tag;
      v.exp.mode = mode;  v.exp.x = ex;  v.exp.y = ey;  v.exp.theta = eth;
      v.exp.q = q;  v.exp.tag = tag;  v.exp.sat = esat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic drive(input logic mode, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] th, input logic [3:0] tag);
      in_valid = 1'b1;
      in_mode  = mode;
      in_x     = x;
      in_y     = y;
      in_theta = th;
      in_tag   = tag;
      cur_exp  = model(mode, x, y, th, tag);
   endtask

   // Samples handshakes at the negedge (equivalent to the next posedge) and returns at posedge+1.
   task automatic cycle(output bit acc);
      beat_t e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         n_out++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out actual_tag=%0d required=no_beat", out_tag);
         end else begin
            e = sb.pop_front();
            if ({out_mode, out_x, out_y, out_theta, out_quadrant, out_tag, out_sat} !== pack(e)) begin
               failures++;
               $display("FAIL out_beat tag=%0d actual=%h required=%h", e.tag,
                        {out_mode, out_x, out_y, out_theta, out_quadrant, out_tag, out_sat}, pack(e));
            end else begin
               $display("beat tag=%0d q=%0d x=%h y=%h theta=%h sat=%0b", out_tag, out_quadrant,
                        out_x, out_y, out_theta, out_sat);
            end
         end
      end
      acc = in_valid && in_ready;
      if (acc) sb.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      bit acc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(acc);
      chk(nm, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      int n_acc;
      int n_start;
      logic [15:0] rx;
      logic [15:0] ry;

      checks = 0;  failures = 0;  n_out = 0;
      rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
      in_mode = 1'b0;  in_x = '0;  in_y = '0;  in_theta = '0;  in_tag = '0;

      tbl[0] = mkv(1'b0, 16'h4000, 16'h0000, 16'h6000, 4'd1, 2'd1, 16'h0000, 16'hC000, 16'h2000, 1'b0);
      tbl[1] = mkv(1'b1, 16'hC000, 16'hE000, 16'h1234, 4'd2, 2'd2, 16'h4000, 16'h2000, 16'h8000, 1'b0);
      tbl[2] = mkv(1'b0, 16'h8000, 16'h0000, 16'h8000, 4'd3, 2'd2, SX,       16'h0000, 16'h0000, SAT);
      tbl[3] = mkv(1'b1, 16'h1000, 16'h2000, 16'hFFFF, 4'd4, 2'd0, 16'h1000, 16'h2000, 16'h0000, 1'b0);
      tbl[4] = mkv(1'b1, 16'hF000, 16'h0100, 16'h0000, 4'd5, 2'd1, 16'h0100, 16'h1000, 16'h4000, 1'b0);
      tbl[5] = mkv(1'b1, 16'h0300, 16'h8000, 16'h0000, 4'd6, 2'd3, SX,       16'h0300, 16'hC000, SAT);
      tbl[6] = mkv(1'b0, 16'h1234, 16'h5678, 16'hFFFF, 4'd7, 2'd3, 16'hA988, 16'h1234, 16'h3FFF, 1'b0);
      tbl[7] = mkv(1'b0, 16'h7FFF, 16'h8001, 16'h0000, 4'd8, 2'd0, 16'h7FFF, 16'h8001, 16'h0000, 1'b0);
      tbl[8] = mkv(1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd9, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready_low", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      chk("rel_out_valid", 64'(out_valid), 64'd0);
      chk("rel_out_data", 64'({out_x, out_y, out_theta}), 64'd0);
      chk("rel_out_side", 64'({out_mode, out_quadrant, out_tag, out_sat}), 64'd0);

      // Vector table with hand-derived expectations
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].theta, tbl[i].tag);
         cur_exp = tbl[i].exp;
         cycle(acc);
         chk("tbl_accept", 64'(acc), 64'd1);
      end
      drain("tbl_drain");

      // Back-pressure: tag1 held on output, tag2 in skid, tag3 waits
      out_ready = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         drive(1'b0, 16'(16'h0100 * t), 16'h0011, 16'(16'h4000 * t + 5), 4'(t));
         cycle(acc);
      end
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_tag", 64'(out_tag), 64'd1);
      chk("bp_queued", 64'(sb.size()), 64'd2);
      out_ready = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 10 && n_acc == 0; i++) begin
         cycle(acc);
         if (acc) n_acc++;
      end
      chk("bp_tag3_accept", 64'(n_acc), 64'd1);
      drain("bp_drain");

      // Reset with output held and skid full
      out_ready = 1'b0;
      drive(1'b1, 16'h8123, 16'h0456, 16'h0000, 4'd10);
      cycle(acc);
      drive(1'b0, 16'h1111, 16'h2222, 16'hC333, 4'd11);
      cycle(acc);
      in_valid = 1'b0;
      chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      sb.delete();
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_out_data", 64'({out_x, out_y, out_theta}), 64'd0);
      chk("mid_rst_out_side", 64'({out_mode, out_quadrant, out_tag, out_sat}), 64'd0);
      @(posedge clk);
      #1;

      // 100 random beats, full throughput
      out_ready = 1'b1;
      n_acc = 0;
      n_start = n_out;
      for (int i = 0; i < 100; i++) begin
         rx = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         ry = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         drive(1'($urandom_range(0, 1)), rx, ry, 16'($urandom), 4'(i));
         cycle(acc);
         if (acc) n_acc++;
      end
      in_valid = 1'b0;
      cycle(acc);
      chk("rand_accepted", 64'(n_acc), 64'd100);
      chk("rand_outputs", 64'(n_out - n_start), 64'd100);
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
